// File: rtl/seg7_pkg.sv
// Shared 7-segment code table (active-low, bit 0 = segment a) and scan-reader FSM states.
package seg7_pkg;

  localparam logic [0:6] SEG7_CODE_0 = 7'b0000001;
  localparam logic [0:6] SEG7_CODE_1 = 7'b1001111;
  localparam logic [0:6] SEG7_CODE_2 = 7'b0010010;
  localparam logic [0:6] SEG7_CODE_3 = 7'b0000110;
  localparam logic [0:6] SEG7_CODE_4 = 7'b1001100;
  localparam logic [0:6] SEG7_CODE_5 = 7'b0100100;
  localparam logic [0:6] SEG7_CODE_6 = 7'b0100000;
  localparam logic [0:6] SEG7_CODE_7 = 7'b0001111;
  localparam logic [0:6] SEG7_CODE_8 = 7'b0000000;
  localparam logic [0:6] SEG7_CODE_9 = 7'b0000100;
  localparam logic [0:6] SEG7_CODE_A = 7'b0001000;
  localparam logic [0:6] SEG7_CODE_B = 7'b1100000;
  localparam logic [0:6] SEG7_CODE_C = 7'b0110001;
  localparam logic [0:6] SEG7_CODE_D = 7'b1000010;
  localparam logic [0:6] SEG7_CODE_E = 7'b0110000;
  localparam logic [0:6] SEG7_CODE_F = 7'b0111000;
  localparam logic [0:6] SEG7_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HELD  = 2'd2
  } seg7_state_t;

  function automatic logic [0:6] seg7_code(input logic [3:0] nib);
    logic [0:6] code;
    case (nib)
      4'h0: code = SEG7_CODE_0;
      4'h1: code = SEG7_CODE_1;
      4'h2: code = SEG7_CODE_2;
      4'h3: code = SEG7_CODE_3;
      4'h4: code = SEG7_CODE_4;
      4'h5: code = SEG7_CODE_5;
      4'h6: code = SEG7_CODE_6;
      4'h7: code = SEG7_CODE_7;
      4'h8: code = SEG7_CODE_8;
      4'h9: code = SEG7_CODE_9;
      4'hA: code = SEG7_CODE_A;
      4'hB: code = SEG7_CODE_B;
      4'hC: code = SEG7_CODE_C;
      4'hD: code = SEG7_CODE_D;
      4'hE: code = SEG7_CODE_E;
      default: code = SEG7_CODE_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder: segment pattern -> {legal, nibble}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == seg7_code(4'(i))) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed active-low 7-segment bus back into a hex frame.
// Define SEG7_DP_EN to also capture the decimal point per digit (dp / dp_mask ports).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  localparam int unsigned ERR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:6]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG7_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic                    code_err,
  output logic [ERR_W-1:0]        err_digit
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_DP_EN
  localparam int unsigned SMP_W = 8 + NUM_DIGITS;
`else
  localparam int unsigned SMP_W = 7 + NUM_DIGITS;
`endif

  logic [0:6]              seg_q1, s_seg;
  logic [NUM_DIGITS-1:0]   an_q1, s_an;
  logic [SMP_W-1:0]        smp, prev_smp;
  logic [CNT_W-1:0]        cnt;
  seg7_state_t             state;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [NUM_DIGITS-1:0]   seen;
  logic                    err_pend;
  logic [ERR_W-1:0]        err_pend_digit, dig_idx;
  logic                    one_hot, changed, capture, legal;
  logic [3:0]              nibble;

`ifdef SEG7_DP_EN
  logic                  dp_q1, s_dp;
  logic [NUM_DIGITS-1:0] staging_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q1 <= 1'b1;
      s_dp  <= 1'b1;
    end else begin
      dp_q1 <= dp;
      s_dp  <= dp_q1;
    end
  end

  assign smp = {s_dp, s_seg, s_an};
`else
  assign smp = {s_seg, s_an};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q1 <= '1;
      s_seg  <= '1;
      an_q1  <= '1;
      s_an   <= '1;
    end else begin
      seg_q1 <= seg;
      s_seg  <= seg_q1;
      an_q1  <= an;
      s_an   <= an_q1;
    end
  end

  assign one_hot = $onehot(~s_an);
  assign changed = (smp != prev_smp);
  // The STABLE_CYCLES-th identical sample triggers the capture on the same edge.
  assign capture = (state == ST_DWELL) && one_hot && !changed &&
                   (cnt == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    dig_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) dig_idx = ERR_W'(i);
    end
  end

  seg7_pattern_decode u_decode (
    .seg    (s_seg),
    .legal  (legal),
    .nibble (nibble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      cnt      <= '0;
      prev_smp <= '0;
    end else begin
      prev_smp <= smp;
      case (state)
        ST_WAIT: begin
          if (one_hot) begin
            state <= ST_DWELL;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_DWELL: begin
          if (!one_hot) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (changed) begin
            cnt <= CNT_W'(1);
          end else if (capture) begin
            state <= ST_HELD;
            cnt   <= CNT_W'(STABLE_CYCLES);
          end else if (cnt < CNT_W'(STABLE_CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (changed) begin
            state <= one_hot ? ST_DWELL : ST_WAIT;
            cnt   <= one_hot ? CNT_W'(1) : '0;
          end
        end
        default: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging        <= '0;
      seen           <= '0;
      value          <= '0;
      frame_valid    <= 1'b0;
      code_err       <= 1'b0;
      err_digit      <= '0;
      err_pend       <= 1'b0;
      err_pend_digit <= '0;
`ifdef SEG7_DP_EN
      staging_dp     <= '0;
      dp_mask        <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      code_err    <= err_pend;
      err_pend    <= 1'b0;
      if (err_pend) err_digit <= err_pend_digit;

      if (&seen) begin
        value       <= staging;
        frame_valid <= 1'b1;
        seen        <= '0;
`ifdef SEG7_DP_EN
        dp_mask     <= staging_dp;
`endif
      end

      if (capture) begin
        if (legal) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) begin
              staging[4*i +: 4] <= nibble;
              seen[i]           <= 1'b1;
`ifdef SEG7_DP_EN
              staging_dp[i]     <= ~s_dp;
`endif
            end
          end
        end else begin
          err_pend       <= 1'b1;
          err_pend_digit <= dig_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a frame/error scoreboard.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:6]  seg = SEG7_BLANK;
  logic [3:0]  an = 4'hF;
  logic [15:0] value;
  logic        frame_valid, code_err;
  logic [1:0]  err_digit;
`ifdef SEG7_DP_EN
  logic        dp = 1'b1;
  logic [3:0]  dp_mask;
`endif

  int passed = 0;
  int total = 0;
  int frame_cnt = 0;
  int err_cnt = 0;
  int f0;
  logic [15:0] exp_q[$];
  logic [1:0]  err_q[$];

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
`ifdef SEG7_DP_EN
    .dp          (dp),
    .dp_mask     (dp_mask),
`endif
    .value       (value),
    .frame_valid (frame_valid),
    .code_err    (code_err),
    .err_digit   (err_digit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] a, input logic [0:6] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        frame_cnt++;
        if (exp_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
        else chk("frame_value", 32'(value), 32'(exp_q.pop_front()));
      end
      if (code_err) begin
        err_cnt++;
        if (err_q.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
        else chk("err_digit", 32'(err_digit), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    // 1: reset and idle bus
    repeat (5) @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(code_err), 32'h0);
    chk("rst_err_digit", 32'(err_digit), 32'h0);
    rst_n = 1'b1;
    drive(4'hF, SEG7_BLANK, 100);
    chk("idle_frames", 32'(frame_cnt), 32'd0);
    chk("idle_errs", 32'(err_cnt), 32'd0);

    // 2: single digit capture
    drive(4'b1110, SEG7_CODE_3, 20);
    chk("d0_seen", 32'(dut.seen), 32'b0001);
    chk("d0_staging", 32'(dut.staging[3:0]), 32'h3);
    chk("d0_no_frame", 32'(frame_cnt), 32'd0);
    drive(4'hF, SEG7_BLANK, 4);

    // 3: full scan
    do_reset();
    exp_q.push_back(16'h1234);
    drive(4'b0111, SEG7_CODE_1, 20);
    drive(4'b1011, SEG7_CODE_2, 20);
    drive(4'b1101, SEG7_CODE_3, 20);
    drive(4'b1110, SEG7_CODE_4, 20);
    drive(4'hF, SEG7_BLANK, 5);
    chk("scan_frames", 32'(frame_cnt), 32'd1);
    chk("scan_value", 32'(value), 32'h1234);
    chk("scan_seen_clr", 32'(dut.seen), 32'h0);

    // 4: short glitch inside a dwell
    drive(4'b1110, SEG7_CODE_9, 20);
    drive(4'b1110, SEG7_CODE_2, 7);
    chk("glitch_hold", 32'(dut.staging[3:0]), 32'h9);
    drive(4'b1110, SEG7_CODE_9, 20);
    chk("glitch_after", 32'(dut.staging[3:0]), 32'h9);
    chk("glitch_seen", 32'(dut.seen), 32'b0001);

    // 5: illegal pattern, then two anodes low
    err_q.push_back(2'd1);
    drive(4'b1101, SEG7_BLANK, 20);
    drive(4'hF, SEG7_BLANK, 4);
    chk("blank_err_cnt", 32'(err_cnt), 32'd1);
    chk("blank_err_digit", 32'(err_digit), 32'd1);
    chk("blank_seen", 32'(dut.seen), 32'b0001);
    drive(4'b1100, SEG7_CODE_8, 20);
    drive(4'hF, SEG7_BLANK, 4);
    chk("multi_an_err", 32'(err_cnt), 32'd1);
    chk("multi_an_seen", 32'(dut.seen), 32'b0001);

    // 6: reset during a partial frame
    do_reset();
    drive(4'b1110, SEG7_CODE_5, 20);
    drive(4'b1101, SEG7_CODE_6, 20);
    drive(4'b1011, SEG7_CODE_7, 20);
    chk("part_seen", 32'(dut.seen), 32'b0111);
    f0 = frame_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_seen", 32'(dut.seen), 32'h0);
    chk("midrst_value", 32'(value), 32'h0);
    rst_n = 1'b1;
    drive(4'b0111, SEG7_CODE_A, 20);
    chk("post_rst_value", 32'(value), 32'h0);
    chk("post_rst_frames", 32'(frame_cnt), 32'(f0));
    exp_q.push_back(16'hACDE);
    drive(4'b1011, SEG7_CODE_C, 20);
    drive(4'b1101, SEG7_CODE_D, 20);
    drive(4'b1110, SEG7_CODE_E, 20);
    drive(4'hF, SEG7_BLANK, 5);
    chk("fresh_frames", 32'(frame_cnt), 32'(f0 + 1));
    chk("fresh_value", 32'(value), 32'hACDE);

`ifdef SEG7_DP_EN
    do_reset();
    exp_q.push_back(16'h5678);
    drive(4'b0111, SEG7_CODE_5, 20);
    dp = 1'b0;
    drive(4'b1011, SEG7_CODE_6, 20);
    dp = 1'b1;
    drive(4'b1101, SEG7_CODE_7, 20);
    drive(4'b1110, SEG7_CODE_8, 20);
    drive(4'hF, SEG7_BLANK, 5);
    chk("dp_value", 32'(value), 32'h5678);
    chk("dp_mask", 32'(dp_mask), 32'b0100);
`endif

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
